// File: rtl/main_mem_responder.sv
// -----------------------------------------------------------------------------
// main_mem_responder
//
// Word-addressed main-memory model at the bottom of the 16-bit CPU's memory
// hierarchy. It answers the cache arbiter's memory port:
//   - reads are pipelined with a fixed LATENCY and one read can be accepted
//     every cycle, so a cache fill can stream a whole block back-to-back;
//   - writes (dcache write-through) complete in the cycle they are presented.
//
// Parameters
//   LATENCY : cycles from read acceptance to data_valid (legal 1..8)
//   WORDS   : number of 16-bit words stored; word index = addr[15:1] % WORDS
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   enable     in   1   request strobe; 0 = idle cycle
//   wr         in   1   1 = write, 0 = read (qualified by enable)
//   addr       in  16   byte address; bit 0 not used for indexing
//   data_in    in  16   write data
//   data_out   out 16   read data; forced to 0 whenever data_valid = 0
//   data_valid out  1   one-cycle pulse per returned read
//   pending    out  4   reads accepted but not yet returned (0..LATENCY)
//   err        out  1   sticky misaligned-access flag
//
// Configuration
//   MEM_MISALIGN_ERR_EN : when defined, err sets on any enabled access with
//                         addr[0] = 1 and holds until rst. When undefined,
//                         err is tied to 0 and no detection logic exists.
//
// Reset clears the read pipeline, pending and err. Reads in flight at reset
// are dropped. The storage array itself keeps its contents across reset.
// -----------------------------------------------------------------------------
module main_mem_responder #(
  parameter int LATENCY = 4,
  parameter int WORDS   = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  pending,
  output logic        err
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [15:0]      word_t;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic  accept_read;
  logic  accept_write;
  logic  return_read;
  idx_t  word_idx;
  word_t rd_word;

  assign accept_read  = enable & ~wr;
  assign accept_write = enable &  wr;

  // Word index wraps modulo WORDS; addresses above the array alias onto low
  // words by design, so no range error is raised for them.
  assign word_idx = idx_t'(32'(addr[15:1]) % 32'(WORDS));

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  word_t mem [WORDS];

  // Combinational look-up: the value registered into pipeline stage 0 at a
  // read edge is the array content before that edge, which is exactly the
  // snapshot a later write must not disturb.
  assign rd_word = mem[word_idx];

  // NOTE: the array has no reset branch on purpose -- contents must survive
  // rst, and leaving it out keeps the array mappable onto RAM.
  always_ff @(posedge clk) begin
    if (accept_write) begin
      mem[word_idx] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return pipeline: LATENCY stages of {valid, data}. Stage 0 loads at
  // the acceptance edge; the last stage drives the outputs directly, so a read
  // accepted at edge N is visible after edge N+LATENCY-1.
  // Idle stages carry data 0, which keeps data_out at 0 when nothing returns.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] valid_d;
  word_t              data_q [LATENCY];
  word_t              data_d [LATENCY];
  logic [3:0]         pending_q;
  logic [3:0]         pending_d;

  // A read leaves the pipeline at the edge that shifts it out of the last
  // stage, i.e. one edge after it first appears on data_valid.
  assign return_read = valid_q[LATENCY-1];

  // NOTE: every always_comb output is assigned before any conditional logic,
  // so no path can leave a value held and infer a latch.
  always_comb begin
    valid_d   = '0;
    pending_d = pending_q;
    for (int k = 0; k < LATENCY; k++) begin
      data_d[k] = '0;
    end

    valid_d[0] = accept_read;
    data_d[0]  = accept_read ? rd_word : '0;
    for (int k = 1; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = data_q[k-1];
    end

    // Accept and return on the same edge cancel out; the count can never
    // pass LATENCY because every accepted read returns LATENCY edges later.
    pending_d = pending_q + 4'(accept_read) - 4'(return_read);
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the shift cannot race through.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      pending_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      for (int k = 0; k < LATENCY; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign data_out   = data_q[LATENCY-1];
  assign data_valid = valid_q[LATENCY-1];
  assign pending    = pending_q;

  // ---------------------------------------------------------------------------
  // Misaligned-access flag
  // ---------------------------------------------------------------------------
`ifdef MEM_MISALIGN_ERR_EN
  logic err_q;
  logic err_d;

  // Sticky: once set, only rst clears it. The access itself still proceeds
  // with addr[15:1].
  assign err_d = err_q | (enable & addr[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Without detection the byte-select bit has no consumer at all.
  logic unused_addr_lsb;
  assign unused_addr_lsb = addr[0];

  assign err = 1'b0;
`endif

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Word-addressed main-memory model that answers the cache arbiter's memory port: `mainmem_addr`, `mainmem_wr`, `mainmem_write_data` in; `mainmem_read_data`, `mainmem_data_valid` out.
- Reads are pipelined with fixed latency. One new read can be accepted every cycle, so a cache fill FSM can stream 8 block addresses back-to-back.
- Writes (dcache write-through) complete in one cycle.
- Sits between the cache arbiter and nothing else; it is the bottom of the memory hierarchy for the 16-bit CPU.

Parameters:
- LATENCY, 4, cycles from read acceptance to `data_valid`; legal range 1..8.
- WORDS, 32768, number of 16-bit words stored; word index = `addr[15:1]` modulo WORDS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  request strobe; when 0, the cycle is idle
- wr  input  1  1 = write request, 0 = read request (qualified by `enable`)
- addr  input  16  byte address; bit 0 ignored for array indexing
- data_in  input  16  write data
- data_out  output  16  read data; valid only when `data_valid` = 1
- data_valid  output  1  high for exactly one cycle per returned read
- pending  output  4  number of reads accepted but not yet returned (0..LATENCY)
- err  output  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Reset (`rst` = 1 at posedge):
  - clears all pipeline valid bits, `data_valid` = 0, `data_out` = 16'h0000, `pending` = 0, `err` = 0.
  - Memory array contents are NOT cleared.
  - Reads in flight at reset are dropped; none is returned afterwards.
- Write:
  - `enable` = 1 and `wr` = 1 at posedge: `mem[addr[15:1] % WORDS]` <= `data_in`.
  - No `data_valid` is generated; `pending` is unchanged by the write.
- Read acceptance:
  - `enable` = 1 and `wr` = 0 at posedge N: array word sampled at posedge N, before any write from the same edge (no write occurs in the same cycle, since `wr` = 0).
  - Sampled value enters a LATENCY-deep shift pipeline of {valid, data}.
- Read return:
  - `data_valid` = 1 and `data_out` = sampled word during the cycle following posedge N+LATENCY-1, i.e. visible LATENCY cycles after the request cycle.
  - For LATENCY = 1, data appears the cycle after the request.
- Ordering: responses return strictly in request order; every cycle the pipeline shifts by one stage.
- Back-to-back: reads on consecutive cycles produce `data_valid` on consecutive cycles. Gaps in requests produce identical gaps in responses.
- Hazards:
  - A write to address A after a read to A is accepted does not alter that read's returned data (snapshot at acceptance).
  - A read of A accepted the cycle after a write to A returns the new data.
- Idle output: `data_out` = 16'h0000 whenever `data_valid` = 0; no stale data is exposed.
- `pending` arithmetic:
  - `pending_next = pending + accept_read - return_read`.
  - Simultaneous accept and return leaves it unchanged.
  - Never exceeds LATENCY; width 4 bits covers LATENCY ≤ 8.
- Address wrap: word index taken modulo WORDS. Addresses above the array alias onto low words; this is not an error.
- `enable` = 0: `wr`, `addr`, `data_in` are ignored.
- No backpressure: the consumer must accept data on the `data_valid` cycle.

Optional Feature:
- Macro: `MEM_MISALIGN_ERR_EN`
- Defined:
  - `err` sets at the posedge where `enable` = 1 and `addr[0]` = 1, for both reads and writes.
  - `err` stays 1 until `rst`.
  - The access still proceeds using `addr[15:1]`.
- Not defined: `err` is tied to 0, and no detection logic is synthesised.

Test Plan:
- Reset and idle: `rst` for 2 cycles, then idle 10 cycles -> `data_valid` = 0, `data_out` = 16'h0000, `pending` = 0, `err` = 0 throughout.
- Write then read: write 16'hBEEF to 16'h0010; next cycle read 16'h0010 with LATENCY = 4 -> `data_valid` = 1 exactly 4 cycles after the read cycle, with `data_out` = 16'hBEEF; `pending` goes 1,1,1,1,0.
- Block stream:
  - Preload 16'h0100 + i at addresses 16'h0040 + 2i, i = 0..7.
  - Issue 8 consecutive reads.
  - Expect 8 consecutive `data_valid` cycles with data 16'h0100..16'h0107 in order, and `pending` peaks at 4.
- Snapshot hazard: read 16'h0020 (holding 16'h1111), then next cycle write 16'h2222 to 16'h0020 -> the read returns 16'h1111; a following read returns 16'h2222.
- Reset mid-flight: issue 3 reads, assert `rst` 2 cycles later -> no `data_valid` ever appears for them, `pending` = 0, and memory still holds the preloaded values.
- Misalign and wrap (`MEM_MISALIGN_ERR_EN` defined, WORDS = 16):
  - Read 16'h0003 -> `err` = 1 from the next cycle and stays high; returns `mem[1]`.
  - Read 16'h0022 -> returns `mem[1]` (wrap).
  - With the macro undefined, `err` stays 0.
